// File: rtl/census_xppc_if.sv
// rtl/census_xppc_if.sv - context-window input stream and census video output stream bundle
interface census_xppc_if #(
    parameter int BITS_PER_PIXEL = 8,
    parameter int CONTEXT_SIZE   = 3,
    parameter int N_CNTX         = 13
);
    localparam int CENSUS_BITS = CONTEXT_SIZE * CONTEXT_SIZE - 1;
    localparam int TDATA_WIDTH = N_CNTX * CENSUS_BITS;

    // windows indexed [column][row][context]
    logic [CONTEXT_SIZE-1:0][CONTEXT_SIZE-1:0][N_CNTX-1:0][BITS_PER_PIXEL-1:0] in_cntx;
    logic [N_CNTX-1:0]      in_pixel_valid;
    logic                   in_tvalid;
    logic                   in_tlast;
    logic                   in_tuser;
    logic                   in_tready;

    logic [TDATA_WIDTH-1:0] VIDEO_OUT_tdata;
    logic                   VIDEO_OUT_tvalid;
    logic                   VIDEO_OUT_tlast;
    logic                   VIDEO_OUT_tuser;
    logic                   VIDEO_OUT_tready;
    logic [N_CNTX-1:0]      out_valid_mask;

    // stream environment: feeds contexts, consumes census beats
    modport master (
        output in_cntx, in_pixel_valid, in_tvalid, in_tlast, in_tuser,
        input  in_tready,
        input  VIDEO_OUT_tdata, VIDEO_OUT_tvalid, VIDEO_OUT_tlast, VIDEO_OUT_tuser,
        output VIDEO_OUT_tready,
        input  out_valid_mask
    );

    // census stage: consumes contexts, produces census beats
    modport slave (
        input  in_cntx, in_pixel_valid, in_tvalid, in_tlast, in_tuser,
        output in_tready,
        output VIDEO_OUT_tdata, VIDEO_OUT_tvalid, VIDEO_OUT_tlast, VIDEO_OUT_tuser,
        input  VIDEO_OUT_tready,
        output out_valid_mask
    );
endinterface

// File: rtl/census_xppc.sv
// rtl/census_xppc.sv - two-stage elastic census transform over N context windows with line-length check
module census_xppc #(
    parameter int SAMPLES_PER_CLOCK = 4,
    parameter int BITS_PER_PIXEL    = 8,
    parameter int CONTEXT_SIZE      = 3,
    parameter int N_CNTX            = 13,
    parameter int WIDTH             = 3840,
    parameter int GROUPS            = WIDTH / SAMPLES_PER_CLOCK,
    parameter int CENSUS_BITS       = CONTEXT_SIZE * CONTEXT_SIZE - 1,
    parameter int TDATA_WIDTH       = N_CNTX * CENSUS_BITS
) (
    input  logic         s_axis_aclk,
    input  logic         s_axis_areset,
    census_xppc_if.slave bus,
    output logic         line_len_err
);
    localparam int B          = (CONTEXT_SIZE - 1) / 2;
    localparam int CENTRE_LIN = B * CONTEXT_SIZE + B;
    localparam int CW         = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(GROUPS - 1);

    // raw comparison bits for the beat currently on the input
    logic [N_CNTX-1:0][CENSUS_BITS-1:0] cmp;

    // stage 1: unmasked comparison vectors plus sideband
    logic                               s1_valid;
    logic [N_CNTX-1:0][CENSUS_BITS-1:0] s1_cmp;
    logic [N_CNTX-1:0]                  s1_mask;
    logic                               s1_tlast;
    logic                               s1_tuser;

    // stage 2: masked census words, directly drives the output stream
    logic                               s2_valid;
    logic [N_CNTX-1:0][CENSUS_BITS-1:0] s2_word;
    logic [N_CNTX-1:0]                  s2_mask;
    logic                               s2_tlast;
    logic                               s2_tuser;

    logic          s1_ready;
    logic          s2_ready;
    logic          in_fire;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] beat_eff;

    // Neighbours are scanned row-major skipping the centre, so the linear
    // position drops by one once we are past the centre.
    for (genvar j = 0; j < N_CNTX; j++) begin : g_ctx
        for (genvar r = 0; r < CONTEXT_SIZE; r++) begin : g_row
            for (genvar c = 0; c < CONTEXT_SIZE; c++) begin : g_col
                localparam int LIN = r * CONTEXT_SIZE + c;
                localparam int K   = (LIN > CENTRE_LIN) ? LIN - 1 : LIN;
                if (LIN != CENTRE_LIN) begin : g_cmp
                    assign cmp[j][K] = (bus.in_cntx[c][r][j] < bus.in_cntx[B][B][j]);
                end
            end
        end
    end

    // Ready chain runs from the output back; in_valid never feeds in_tready.
    assign s2_ready      = !s2_valid || bus.VIDEO_OUT_tready;
    assign s1_ready      = !s1_valid || s2_ready;
    assign bus.in_tready = s1_ready && !s_axis_areset;
    assign in_fire       = bus.in_tvalid && bus.in_tready;

    // Nothing leaves during the reset cycle, even though the stage is still loaded.
    assign bus.VIDEO_OUT_tvalid = s2_valid && !s_axis_areset;
    assign bus.VIDEO_OUT_tdata  = s2_word;
    assign bus.VIDEO_OUT_tlast  = s2_tlast;
    assign bus.VIDEO_OUT_tuser  = s2_tuser;
    assign bus.out_valid_mask   = s2_mask;

    // Stage 1 load: capture comparisons whenever the stage can take a beat
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            s1_valid <= 1'b0;
            s1_cmp   <= '0;
            s1_mask  <= '0;
            s1_tlast <= 1'b0;
            s1_tuser <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= bus.in_tvalid;
            if (bus.in_tvalid) begin
                s1_cmp   <= cmp;
                s1_mask  <= bus.in_pixel_valid;
                s1_tlast <= bus.in_tlast;
                s1_tuser <= bus.in_tuser;
            end
        end
    end

    // Stage 2 load: zero invalid contexts; holds steady while the output stalls
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            s2_valid <= 1'b0;
            s2_word  <= '0;
            s2_mask  <= '0;
            s2_tlast <= 1'b0;
            s2_tuser <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                for (int j = 0; j < N_CNTX; j++) begin
                    s2_word[j] <= s1_mask[j] ? s1_cmp[j] : '0;
                end
                s2_mask  <= s1_mask;
                s2_tlast <= s1_tlast;
                s2_tuser <= s1_tuser;
            end
        end
    end

    // Start-of-frame restarts the line, so the beat carrying tuser counts as beat 0
    always_comb begin
        beat_eff = bus.in_tuser ? '0 : beat_cnt;
    end

    // Line checker: every mis-placed or missing tlast latches the sticky error
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            beat_cnt     <= '0;
            line_len_err <= 1'b0;
        end else if (in_fire) begin
            if (bus.in_tlast) begin
                beat_cnt <= '0;
                if (beat_eff != LAST_BEAT) begin
                    line_len_err <= 1'b1;
                end
            end else if (beat_eff == LAST_BEAT) begin
                beat_cnt     <= '0;
                line_len_err <= 1'b1;
            end else begin
                beat_cnt <= beat_eff + 1'b1;
            end
        end
    end
endmodule

// File: doc/census_xppc.md
# census_xppc

Census-transform stage placed directly downstream of the N-context generator in the stereovision pipeline. Each beat it takes N_CNTX square CONTEXT_SIZE×CONTEXT_SIZE pixel windows plus per-context validity flags, and turns every window into a census bit-string. The result goes out as a multi-sample AXI4-Stream video beat for the matching-cost stage. The block is a 2-stage elastic pipeline with full backpressure. It passes tuser/tlast through unchanged and checks line length against WIDTH.

## Interface
Parameters:
- SAMPLES_PER_CLOCK, 4, samples per input video beat; used only for line-length checking.
- BITS_PER_PIXEL, 8, pixel width.
- CONTEXT_SIZE, 3, window side; odd, 3..9.
- N_CNTX, 13, contexts per beat.
- WIDTH, 3840, pixels per line.
- GROUPS, WIDTH/SAMPLES_PER_CLOCK, expected beats per line.
- CENSUS_BITS, CONTEXT_SIZE*CONTEXT_SIZE-1, census bits per context.
- TDATA_WIDTH, N_CNTX*CENSUS_BITS, output data width.

Ports:
- s_axis_aclk, in, 1, single clock.
- s_axis_areset, in, 1, synchronous active-high reset.
- in_cntx, in, BITS_PER_PIXEL × [CONTEXT_SIZE][CONTEXT_SIZE][N_CNTX], windows indexed [column][row][context].
- in_pixel_valid, in, 1 × [N_CNTX], per-context validity.
- in_tvalid / in_tlast / in_tuser, in, 1 each, context stream qualifiers.
- in_tready, out, 1, ready toward the context generator.
- VIDEO_OUT_tdata, out, TDATA_WIDTH, census words.
- VIDEO_OUT_tvalid / tlast / tuser, out, 1 each.
- VIDEO_OUT_tready, in, 1.
- out_valid_mask, out, N_CNTX, bit j = in_pixel_valid[j] of this beat.
- line_len_err, out, 1, sticky line-length error flag.

## Operation
- Transfer: input on in_tvalid && in_tready; output on VIDEO_OUT_tvalid && VIDEO_OUT_tready.
- Stage 1 registers the comparison vectors. For context j, centre C = in_cntx[B][B][j] with B = (CONTEXT_SIZE-1)/2.
- Census bit ordering:
  - Neighbours are scanned row 0..CONTEXT_SIZE-1 (outer), column 0..CONTEXT_SIZE-1 (inner), skipping the centre.
  - The k-th scanned neighbour sets bit k.
  - Bit k = 1 iff neighbour < C, unsigned strict compare; equal gives 0.
- Stage 2 masking: the census word of any context with in_pixel_valid[j] = 0 is forced to all zeros.
- Output placement: context j goes to VIDEO_OUT_tdata[(j+1)*CENSUS_BITS-1 -: CENSUS_BITS].
- tlast, tuser and the valid mask travel with their data through both stages, unmodified.
- Each stage holds a valid bit.
  - Stage ready = !valid || downstream ready.
  - in_tready = stage-1 ready. This is a combinational chain from VIDEO_OUT_tready; no combinational path from in_tvalid to in_tready.
- in_tready must be exact. The upstream generator advances its internal state on in_tready alone, even in beats where it drives no valid data.
- Line checker, on accepted input beats only:
  - beat counter counts 0..GROUPS-1.
  - in_tlast at counter == GROUPS-1 resets the counter to 0.
  - in_tlast at any other count sets line_len_err and resets the counter.
  - Counter reaching GROUPS-1 without in_tlast sets line_len_err and wraps the counter to 0.
  - in_tuser on an accepted beat forces the count of that beat to 0.
  - line_len_err is cleared only by reset.

## Timing
- Latency: 2 cycles from input acceptance to VIDEO_OUT_tvalid, when unstalled.
- Throughput: 1 beat/cycle.
- Capacity: 2 beats are buffered. With VIDEO_OUT_tready held low, in_tready deasserts in the cycle after the second beat is accepted.
- Output stability: while VIDEO_OUT_tvalid=1 && VIDEO_OUT_tready=0, tdata, tlast, tuser and out_valid_mask stay stable.
- Simultaneous events: stage 2 may accept a new beat in the same cycle it is emptied by an output transfer. No bubble is inserted.
- Reset values: all stage valids, VIDEO_OUT_tvalid/tlast/tuser, out_valid_mask, VIDEO_OUT_tdata, line_len_err and the beat counter are 0. in_tready = 1 from the first cycle after reset.
- Mid-stream reset: in-flight beats are discarded, with no output transfer in the reset cycle. The line checker restarts at count 0.

## Test plan
All scenarios use CONTEXT_SIZE=3, N_CNTX=4, GROUPS=8 (WIDTH=32, SAMPLES_PER_CLOCK=4).
- Census values, all valid, tready=1:
  - centre 100 with all neighbours 50 → word 8'hFF;
  - all neighbours 150 → 8'h00;
  - all neighbours 100 → 8'h00;
  - only [0][0] = 99 → 8'h01;
  - only [2][2] = 0 → 8'h80;
  - each result appears 2 cycles after acceptance.
- Masking: in_pixel_valid = {0,1,1,0} with all-50 neighbours → tdata = 32'h00FFFF00, out_valid_mask = 4'b0110.
- Backpressure:
  - stream 20 beats with incrementing data while VIDEO_OUT_tready toggles randomly;
  - output sequence identical to input order, no loss or duplication;
  - in_tready low only while both stages are full and VIDEO_OUT_tready = 0.
- Sideband passthrough: tuser on beat 0 and tlast on beat 7 of 3 lines → output tuser/tlast on the same beats; line_len_err stays 0.
- Line length errors:
  - tlast on beat 5 → line_len_err = 1 the cycle after acceptance; it stays 1 through later correct lines.
  - Separately, 9 beats without tlast → line_len_err = 1.
- Reset mid-stream: reset asserted while 2 beats are buffered → next cycle all outputs 0 and in_tready = 1; the next frame processes correctly.
